// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter: FSM states, grant ids, abort data.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_e     - transaction sequencer states
//   gnt_e       - requester identity (fetch / load-store)
//   ABORT_DATA  - value loaded into the read-data register on reset and watchdog abort
package pmem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } gnt_e;

  // Replicated/zero-extended to DATA_W where used.
  localparam logic ABORT_DATA = 1'b0;

  // Requester that wins a tie: whichever was not granted last.
  function automatic gnt_e other_grant(input gnt_e g);
    return (g == GNT_LS) ? GNT_IF : GNT_LS;
  endfunction

endpackage

// File: rtl/pmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: chooses fetch or load/store from two request valids.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
//
// Ports:
//   if_valid, ls_valid - request pending from each requester
//   last_grant         - requester that won the previous accepted transaction
//   grant              - chosen requester (only meaningful when any_valid)
//   any_valid          - at least one request pending
module rr_pick2
  import pmem_arb_pkg::*;
(
  input  logic if_valid,
  input  logic ls_valid,
  input  gnt_e last_grant,
  output gnt_e grant,
  output logic any_valid
);

  always_comb begin
    grant = GNT_IF;
    if (if_valid && ls_valid) begin
      grant = other_grant(last_grant);
    end else if (ls_valid) begin
      grant = GNT_LS;
    end
  end

  assign any_valid = if_valid || ls_valid;

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between instruction fetch and load/store, one transaction at a time.
// Latency: accept at T, memory request from T+1, response pulse one cycle after mem_resp_valid (min 3 cycles).
// Backpressure: requests held until accepted in IDLE; memory request fields held until mem_req_ready.
//
// Ports:
//   clk, rst                      - clock, synchronous active-low reset
//   if_req_valid/ready, if_addr   - fetch request (read-only) handshake
//   if_resp_valid, if_rdata       - fetch response pulse and registered data
//   ls_req_valid/ready, ls_addr,
//   ls_wen, ls_wdata, ls_wmask    - load/store request handshake and fields
//   ls_resp_valid, ls_rdata       - load/store completion pulse and registered data
//   mem_req_valid/ready, mem_addr,
//   mem_wen, mem_wdata, mem_wmask - request to the memory port (latched fields)
//   mem_resp_valid, mem_rdata     - memory response
//   timeout_err                   - one-cycle pulse when the watchdog aborts a transaction
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_resp_valid,
  output logic [DATA_W-1:0]     if_rdata,

  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic                  ls_wen,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [DATA_W/8-1:0]   ls_wmask,
  output logic                  ls_resp_valid,
  output logic [DATA_W-1:0]     ls_rdata,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_rdata,

  output logic                  timeout_err
);

  localparam int MASK_W = DATA_W / 8;

  // A zero TIMEOUT disables the watchdog; keep a 1-bit counter so widths stay legal.
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam int CNT_W = WD_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  localparam logic [DATA_W-1:0] RDATA_ABORT = {DATA_W{ABORT_DATA}};

  state_e           state;
  gnt_e             last_grant;
  gnt_e             owner;
  logic [CNT_W-1:0] wd_cnt;

  gnt_e pick;
  logic any_valid;
  logic accept;
  logic wd_fire;

  rr_pick2 u_pick (
    .if_valid   (if_req_valid),
    .ls_valid   (ls_req_valid),
    .last_grant (last_grant),
    .grant      (pick),
    .any_valid  (any_valid)
  );

  // Acceptance is a combinational one-cycle handshake in IDLE. The rst term keeps
  // every output quiet while reset is asserted, so an in-flight transaction
  // disappears without a response or abort pulse.
  assign accept       = rst && (state == S_IDLE) && any_valid;
  assign if_req_ready = accept && (pick == GNT_IF);
  assign ls_req_ready = accept && (pick == GNT_LS);

  assign mem_req_valid = rst && (state == S_ISSUE);

  // A response arriving in the same cycle as the deadline wins over the abort.
  assign wd_fire = WD_EN && (state == S_WAIT) && !mem_resp_valid && (wd_cnt == CNT_LAST);
  assign timeout_err = rst && wd_fire;

  assign if_resp_valid = rst && (state == S_RESP) && (owner == GNT_IF);
  assign ls_resp_valid = rst && (state == S_RESP) && (owner == GNT_LS);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_grant <= GNT_LS;
      owner      <= GNT_IF;
      wd_cnt     <= '0;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      if_rdata   <= RDATA_ABORT;
      ls_rdata   <= RDATA_ABORT;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            owner      <= pick;
            last_grant <= pick;
            if (pick == GNT_IF) begin
              mem_addr  <= if_addr;
              mem_wen   <= 1'b0;
              mem_wdata <= '0;
              mem_wmask <= {MASK_W{1'b0}};
            end else begin
              mem_addr  <= ls_addr;
              mem_wen   <= ls_wen;
              mem_wdata <= ls_wdata;
              mem_wmask <= ls_wmask;
            end
            state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (mem_req_ready) begin
            wd_cnt <= '0;
            state  <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (mem_resp_valid) begin
            if (owner == GNT_IF) begin
              if_rdata <= mem_rdata;
            end else begin
              ls_rdata <= mem_rdata;
            end
            state <= S_RESP;
          end else if (wd_fire) begin
            if (owner == GNT_IF) begin
              if_rdata <= RDATA_ABORT;
            end else begin
              ls_rdata <= RDATA_ABORT;
            end
            state <= S_RESP;
          end else if (wd_cnt != CNT_SAT) begin
            // Saturate rather than wrap so a disabled watchdog never aliases.
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        S_RESP: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed scoreboard bench for pmem_arbiter with a small behavioural memory.
// Latency: checks exact accept-to-response and watchdog cycle counts.
// Backpressure: memory model can hold mem_req_ready low for a programmable number of cycles.
module tb_pmem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int TMO = 8;
  localparam bit OWN_IF = 1'b0;
  localparam bit OWN_LS = 1'b1;

  logic          clk;
  logic          rst;
  logic          if_req_valid, if_req_ready, if_resp_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic [MW-1:0] ls_wmask;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;
  logic          timeout_err;

  // Memory response is the OR of the model and directed spurious pulses.
  logic          model_resp, spur_resp;
  logic [DW-1:0] model_data, spur_data;
  assign mem_resp_valid = model_resp | spur_resp;
  assign mem_rdata      = model_resp ? model_data : spur_data;

  int  rdy_dly;
  bit  mute;

  typedef struct {
    bit          owner;
    logic [63:0] data;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;

  pmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_addr        (if_addr),
    .if_resp_valid  (if_resp_valid),
    .if_rdata       (if_rdata),
    .ls_req_valid   (ls_req_valid),
    .ls_req_ready   (ls_req_ready),
    .ls_addr        (ls_addr),
    .ls_wen         (ls_wen),
    .ls_wdata       (ls_wdata),
    .ls_wmask       (ls_wmask),
    .ls_resp_valid  (ls_resp_valid),
    .ls_rdata       (ls_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rdata_for(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h0000_0073_0010_0093;
    return {a[31:0] ^ 32'hC0FF_EE00, a[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!(if_req_ready || ls_req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Drops requester valids after the first cycle and counts negedges until a response pulse.
  task automatic wait_resp(output int n);
    n = 0;
    do begin
      cyc();
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      @(negedge clk);
      n++;
    end while (!(if_resp_valid || ls_resp_valid) && n < 60);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 64'(q.size()), 64'd0);
  endtask

  // Behavioural memory: holds ready low rdy_dly cycles, then answers one cycle after acceptance.
  initial begin
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic [MW-1:0] c_wmask;
    logic          c_wen;
    mem_req_ready = 1'b0;
    model_resp    = 1'b0;
    model_data    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req_valid) begin
        c_addr = mem_addr; c_wdata = mem_wdata; c_wmask = mem_wmask; c_wen = mem_wen;
        for (int i = 0; i < rdy_dly; i++) begin
          @(posedge clk);
          #1;
          chk("hold_valid", 64'(mem_req_valid), 64'd1);
          chk("hold_addr", mem_addr, c_addr);
          chk("hold_wdata", mem_wdata, c_wdata);
          chk("hold_wmask", 64'(mem_wmask), 64'(c_wmask));
          chk("hold_wen", 64'(mem_wen), 64'(c_wen));
        end
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        if (!mute) begin
          model_data = rdata_for(c_addr);
          model_resp = 1'b1;
          @(posedge clk);
          #1;
          model_resp = 1'b0;
        end
      end
    end
  end

  // Response monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (if_resp_valid || ls_resp_valid) begin
      exp_t e;
      chk("resp_exclusive", 64'(if_resp_valid && ls_resp_valid), 64'd0);
      chk("resp_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("resp_owner", 64'(ls_resp_valid), 64'(e.owner));
        chk("resp_data", e.owner ? ls_rdata : if_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    int   n;
    int   pulses;
    bit   exp_own;
    rst = 1'b0;
    if_req_valid = 1'b0; if_addr = '0;
    ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
    spur_resp = 1'b0; spur_data = '0;
    rdy_dly = 0; mute = 1'b0;

    // Reset state
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_ctrl", 64'({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid,
                         mem_req_valid, mem_wen, timeout_err}), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
    chk("rst_if_rdata", if_rdata, 64'd0);
    chk("rst_ls_rdata", ls_rdata, 64'd0);
    cyc();
    rst = 1'b1;

    // Lone fetch, memory ready immediately, response one cycle later
    cyc();
    if_req_valid = 1'b1; if_addr = 64'h0000_0000_8000_0000;
    @(negedge clk);
    wait_ready(n);
    chk("if_only_ready", 64'({if_req_ready, ls_req_ready}), 64'b10);
    q.push_back('{OWN_IF, 64'h0000_0073_0010_0093});
    wait_resp(n);
    chk("if_only_latency", 64'(n), 64'd3);
    chk("if_only_resp", 64'({if_resp_valid, ls_resp_valid}), 64'b10);

    // Round-robin after reset: IF, LS, IF, LS with both requesting continuously
    cyc(); rst = 1'b0;
    cyc(); rst = 1'b1;
    if_req_valid = 1'b1; if_addr = 64'h0000_0000_8000_1000;
    ls_req_valid = 1'b1; ls_addr = 64'h0000_0000_8000_2000; ls_wen = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      wait_ready(n);
      if (g > 0) chk("rr_spacing", 64'(n), 64'd3);
      exp_own = (g % 2 == 0) ? OWN_IF : OWN_LS;
      chk("rr_if_ready", 64'(if_req_ready), 64'(exp_own == OWN_IF));
      chk("rr_ls_ready", 64'(ls_req_ready), 64'(exp_own == OWN_LS));
      q.push_back('{exp_own, rdata_for(exp_own ? ls_addr : if_addr)});
      @(negedge clk);
    end
    cyc();
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    drain();

    // LS write with memory stalling ready for 3 cycles
    rdy_dly = 3;
    cyc();
    ls_req_valid = 1'b1; ls_wen = 1'b1; ls_addr = 64'h0000_0000_8000_0100;
    ls_wdata = 64'h0000_0000_DEAD_BEEF; ls_wmask = 8'h0F;
    @(negedge clk);
    wait_ready(n);
    chk("wr_ready", 64'({if_req_ready, ls_req_ready}), 64'b01);
    q.push_back('{OWN_LS, rdata_for(64'h0000_0000_8000_0100)});
    cyc();
    ls_req_valid = 1'b0; ls_addr = 64'hFFFF_0000_1234_5678; ls_wdata = '1; ls_wmask = '0;
    @(negedge clk);
    chk("wr_mem_valid", 64'(mem_req_valid), 64'd1);
    chk("wr_mem_wen", 64'(mem_wen), 64'd1);
    chk("wr_mem_addr", mem_addr, 64'h0000_0000_8000_0100);
    chk("wr_mem_wdata", mem_wdata, 64'h0000_0000_DEAD_BEEF);
    chk("wr_mem_wmask", 64'(mem_wmask), 64'h0F);
    wait_resp(n);
    chk("wr_latency", 64'(n), 64'd5);
    drain();
    rdy_dly = 0;
    ls_wen = 1'b0;

    // Watchdog: memory never answers
    mute = 1'b1;
    cyc();
    ls_req_valid = 1'b1; ls_addr = 64'h0000_0000_8000_0200;
    @(negedge clk);
    wait_ready(n);
    chk("tmo_ready", 64'(ls_req_ready), 64'd1);
    q.push_back('{OWN_LS, 64'd0});
    n = 0;
    do begin
      cyc();
      ls_req_valid = 1'b0;
      @(negedge clk);
      n++;
    end while (!timeout_err && n < 60);
    chk("tmo_err_cycle", 64'(n), 64'd9);
    chk("tmo_err_no_resp", 64'(ls_resp_valid), 64'd0);
    @(negedge clk);
    chk("tmo_resp", 64'(ls_resp_valid), 64'd1);
    chk("tmo_rdata_zero", ls_rdata, 64'd0);
    chk("tmo_err_pulse", 64'(timeout_err), 64'd0);
    cyc();
    spur_resp = 1'b1; spur_data = 64'h1111_2222_3333_4444;
    @(negedge clk);
    cyc();
    spur_resp = 1'b0;
    @(negedge clk);
    chk("late_resp_ignored", 64'({if_resp_valid, ls_resp_valid, mem_req_valid}), 64'd0);
    chk("late_rdata_kept", ls_rdata, 64'd0);
    mute = 1'b0;

    // Reset while in WAIT drops the transaction silently
    mute = 1'b1;
    cyc();
    if_req_valid = 1'b1; if_addr = 64'h0000_0000_8000_0300;
    @(negedge clk);
    wait_ready(n);
    chk("rstw_ready", 64'(if_req_ready), 64'd1);
    repeat (4) begin
      cyc();
      if_req_valid = 1'b0;
      @(negedge clk);
    end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_ctrl", 64'({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid,
                          mem_req_valid, mem_wen, timeout_err}), 64'd0);
    chk("rstw_mem_addr", mem_addr, 64'd0);
    chk("rstw_if_rdata", if_rdata, 64'd0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (if_resp_valid || ls_resp_valid || timeout_err || mem_req_valid) pulses++;
    end
    chk("rstw_quiet", 64'(pulses), 64'd0);
    mute = 1'b0;
    cyc();
    if_req_valid = 1'b1; if_addr = 64'h0000_0000_8000_0500;
    ls_req_valid = 1'b1; ls_addr = 64'h0000_0000_8000_0600;
    @(negedge clk);
    wait_ready(n);
    chk("rstw_tie_if", 64'({if_req_ready, ls_req_ready}), 64'b10);
    q.push_back('{OWN_IF, rdata_for(64'h0000_0000_8000_0500)});
    wait_resp(n);
    chk("rstw_latency", 64'(n), 64'd3);
    drain();

    // Spurious memory responses in IDLE and in ISSUE
    cyc();
    spur_resp = 1'b1; spur_data = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    cyc();
    spur_resp = 1'b0;
    @(negedge clk);
    chk("spur_idle", 64'({if_resp_valid, ls_resp_valid, mem_req_valid}), 64'd0);
    rdy_dly = 2;
    cyc();
    if_req_valid = 1'b1; if_addr = 64'h0000_0000_8000_0400;
    @(negedge clk);
    wait_ready(n);
    chk("spur_ready", 64'(if_req_ready), 64'd1);
    q.push_back('{OWN_IF, rdata_for(64'h0000_0000_8000_0400)});
    cyc();
    if_req_valid = 1'b0;
    spur_resp = 1'b1; spur_data = 64'hBAD1_BAD1_BAD1_BAD1;
    @(negedge clk);
    chk("spur_issue_a", 64'(mem_req_valid), 64'd1);
    cyc();
    spur_resp = 1'b0;
    @(negedge clk);
    chk("spur_issue_b", 64'({mem_req_valid, if_resp_valid, ls_resp_valid}), 64'b100);
    wait_resp(n);
    chk("spur_latency", 64'(n), 64'd3);
    drain();
    rdy_dly = 0;

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Shares the single physical-memory port (the path behind `pmem_read`/`pmem_write`) between instruction fetch (IF) and load/store (LS) once the core moves to multi-cycle operation. Accepts at most one transaction at a time, arbitrates round-robin, sequences the memory handshake through a small FSM, and returns a registered response to the winning requester. A watchdog aborts transactions whose response never arrives.

## Interface
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width; byte mask width is `DATA_W/8`
- `TIMEOUT`, 1024, maximum cycles in WAIT before abort; 0 disables the watchdog

Ports:
- `clk`  in  1  sole clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `if_req_valid`  in  1  fetch request pending (read-only)
- `if_req_ready`  out  1  fetch request accepted this cycle
- `if_addr`  in  ADDR_W  fetch address
- `if_resp_valid`  out  1  one-cycle pulse, `if_rdata` valid
- `if_rdata`  out  DATA_W  fetch read data
- `ls_req_valid`  in  1  load/store request pending
- `ls_req_ready`  out  1  load/store request accepted this cycle
- `ls_addr`  in  ADDR_W  load/store address
- `ls_wen`  in  1  1 = write, 0 = read
- `ls_wdata`  in  DATA_W  store data
- `ls_wmask`  in  DATA_W/8  store byte mask
- `ls_resp_valid`  out  1  one-cycle pulse, completion (reads and writes)
- `ls_rdata`  out  DATA_W  load read data
- `mem_req_valid`  out  1  request to memory
- `mem_req_ready`  in  1  memory accepts request
- `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wmask`  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
- `mem_resp_valid`  in  1  memory response
- `mem_rdata`  in  DATA_W  memory read data
- `timeout_err`  out  1  one-cycle pulse on watchdog abort

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if either `*_req_valid`, pick winner, assert that requester's `*_req_ready` for exactly this cycle, latch addr/wen/wdata/wmask (IF: wen=0, wmask=0, wdata=0) and winner id, go ISSUE. Otherwise stay.
- Arbitration: single requester wins outright; both valid → grant the one not granted last. `last_grant` resets to LS, so IF wins the first tie after reset. `last_grant` updates only on acceptance.
- ISSUE: `mem_req_valid`=1 with latched fields; on `mem_req_ready` go WAIT, clear watchdog counter. Fields stable until accepted.
- WAIT: on `mem_resp_valid`, register `mem_rdata` into winner's rdata register, go RESP. Else increment counter; when counter reaches `TIMEOUT-1` (TIMEOUT≠0), load rdata with 0, pulse `timeout_err`, go RESP.
- RESP: winner's `*_resp_valid`=1 for one cycle, go IDLE. Non-winner rdata register unchanged.
- `mem_resp_valid` outside WAIT is ignored (including late responses after a timeout).
- Requester inputs are sampled only in IDLE; changes elsewhere have no effect.

## Timing
- Reset (`rst`=0 at a rising edge): state IDLE, counter 0, `last_grant`=LS, all outputs 0 (ready, valid, resp_valid, timeout_err, mem_* fields, rdata). Reset mid-transaction drops it silently: no response pulse, no `timeout_err`.
- Accept at cycle T; `mem_req_valid` high from T+1; memory accepts at T+a (a≥1); response at T+a+k (k≥1); `*_resp_valid` at T+a+k+1. Minimum request-to-response: 3 cycles; next acceptance earliest at T+a+k+2.
- Throughput: one transaction per ≥4 cycles; no overlap.
- Watchdog: `timeout_err` and `*_resp_valid` both occur, in consecutive cycles (timeout_err on the WAIT→RESP edge cycle, resp_valid in RESP), `TIMEOUT` cycles after entering WAIT.
- Counter width `$clog2(TIMEOUT+1)`, saturating; never wraps.

## Structure
- Package `pmem_arb_pkg`: state enum (IDLE/ISSUE/WAIT/RESP), grant-id enum (GNT_IF/GNT_LS), reset/abort data constant (0).
- Sub-module `rr_pick2`: combinational 2-way round-robin picker (two valids + last_grant → grant id, any_valid).
- Top holds FSM, request latches, watchdog counter, response registers.

## Test plan
- Only IF valid, addr 0x8000_0000, memory ready immediately, response 1 cycle later with 0x0000_0073_0010_0093 → `if_req_ready` at T, `if_resp_valid` at T+3 with that data; `ls_resp_valid` never.
- Both valid every cycle after reset → grants IF, LS, IF, LS; each grant's response routed only to its owner.
- LS write addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0x0F, memory holds ready low 3 cycles → `mem_*` stable throughout, `mem_wen`=1, `ls_resp_valid` once.
- TIMEOUT=8, memory never responds → `timeout_err` pulse 8 cycles into WAIT, then `ls_rdata`=0 with `ls_resp_valid`; a late `mem_resp_valid` afterwards ignored.
- `rst` low during WAIT → next cycle all outputs 0, IDLE; no resp pulse; next request served normally with IF winning a tie.
- `mem_resp_valid` asserted while IDLE/ISSUE → no state change, no response pulse.
